// File: rtl/pe_out_row_writer.sv
// Drains PE-array output FIFO beats, reassembles HOUT-wide rows per channel,
// applies optional ReLU and writes each row into the next-layer output RAM.
//
// state   | meaning
// ACCEPT  | ready for a beat; pulses rden when upstream valid
// CAPTURE | read data present; shift segment into line buffer
// FLUSH   | write one channel row per accepted RAM write
module pe_out_row_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int HOUT       = 56,
    parameter int Iw         = 7,
    parameter int Wh         = 2,
    parameter int N          = 256,
    parameter int OUT_ROWS   = 56,
    parameter int ADDR_WIDTH = 16,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  pe2row_data_valid,
    input  logic [Wh-1:0][Iw-1:0][DATA_WIDTH-1:0] fifo_array1_dataout,
    output logic [Wh-1:0]                         fifo_array1_rden,
    output logic                                  pe2row_ready,
    output logic                                  out_wr_en,
    input  logic                                  out_wr_ready,
    output logic [ADDR_WIDTH-1:0]                 out_addr,
    output logic [HOUT-1:0][DATA_WIDTH-1:0]       out_data,
    output logic                                  layer_done
);

    localparam int SEGS  = HOUT / Iw;
    localparam int GRPS  = N / Wh;
    localparam int SEG_W = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam int GRP_W = (GRPS > 1) ? $clog2(GRPS) : 1;
    localparam int ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam int WCH_W = (Wh > 1) ? $clog2(Wh) : 1;

    typedef enum logic [1:0] {
        ACCEPT  = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [SEG_W-1:0] seg;
    logic [GRP_W-1:0] grp;
    logic [ROW_W-1:0] row;
    logic [WCH_W-1:0] wch;
    logic [Wh-1:0][HOUT-1:0][DATA_WIDTH-1:0] line;
    logic [HOUT-1:0][DATA_WIDTH-1:0] sel_row;
    logic [HOUT-1:0][DATA_WIDTH-1:0] relu_row;
    logic rd_req;

    logic last_seg, last_grp, last_row, last_wch, wr_fire;

    assign last_seg = (seg == SEG_W'(SEGS - 1));
    assign last_grp = (grp == GRP_W'(GRPS - 1));
    assign last_row = (row == ROW_W'(OUT_ROWS - 1));
    assign last_wch = (wch == WCH_W'(Wh - 1));
    assign wr_fire  = out_wr_en && out_wr_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ACCEPT;
        else     state <= state_nx;
    end

    // All outputs are forced low while reset is asserted.
    always_comb begin
        state_nx     = state;
        pe2row_ready = 1'b0;
        rd_req       = 1'b0;
        out_wr_en    = 1'b0;
        layer_done   = 1'b0;
        case (state)
            ACCEPT: begin
                pe2row_ready = 1'b1;
                if (pe2row_data_valid) begin
                    rd_req   = 1'b1;
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: state_nx = last_seg ? FLUSH : ACCEPT;
            FLUSH: begin
                out_wr_en = 1'b1;
                if (out_wr_ready && last_wch) begin
                    state_nx   = ACCEPT;
                    layer_done = last_grp && last_row;
                end
            end
            default: state_nx = ACCEPT;
        endcase
        if (rst) begin
            pe2row_ready = 1'b0;
            rd_req       = 1'b0;
            out_wr_en    = 1'b0;
            layer_done   = 1'b0;
        end
    end

    assign fifo_array1_rden = {Wh{rd_req}};

    // New segments enter at the top so segment 0 ends up at element 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg  <= '0;
            grp  <= '0;
            row  <= '0;
            wch  <= '0;
            line <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    for (int w = 0; w < Wh; w++)
                        line[w] <= {fifo_array1_dataout[w], line[w][HOUT-1:Iw]};
                    if (last_seg) begin
                        seg <= '0;
                        wch <= '0;
                    end else begin
                        seg <= seg + SEG_W'(1);
                    end
                end
                FLUSH: begin
                    if (wr_fire) begin
                        if (!last_wch) begin
                            wch <= wch + WCH_W'(1);
                        end else begin
                            wch <= '0;
                            if (last_grp) begin
                                grp <= '0;
                                row <= last_row ? '0 : row + ROW_W'(1);
                            end else begin
                                grp <= grp + GRP_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel_row = line[wch];

    for (genvar e = 0; e < HOUT; e++) begin : g_relu
        assign relu_row[e] = (RELU_EN && sel_row[e][DATA_WIDTH-1]) ? '0 : sel_row[e];
    end

    assign out_data = out_wr_en ? relu_row : '0;
    assign out_addr = out_wr_en ? (ADDR_WIDTH'(row) * ADDR_WIDTH'(N)
                                 + ADDR_WIDTH'(grp) * ADDR_WIDTH'(Wh)
                                 + ADDR_WIDTH'(wch)) : '0;

endmodule

// File: tb/tb_pe_out_row_writer.sv
// Directed bench for pe_out_row_writer: Wh=2, Iw=7, HOUT=14, N=4, OUT_ROWS=2,
// with a second instance (ReLU off) sharing the same stimulus.
module tb_pe_out_row_writer;

    typedef logic [1:0][6:0][7:0] beat_t;
    typedef logic [13:0][7:0]     row_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    beat_t       fifo_dout = '0;
    logic        out_wr_ready = 1'b1;

    logic [1:0]  rden, nr_rden;
    logic        ready, nr_ready;
    logic        wr_en, nr_wr_en;
    logic [15:0] addr, nr_addr;
    row_t        data, nr_data;
    logic        ld, nr_ld;

    beat_t       q[$];
    logic        gaps = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          rden_cnt = 0;
    int          viol = 0;
    int          ld_cnt = 0;
    logic [15:0] wr_addr[$];
    row_t        wr_data[$];
    row_t        wr_nr_data[$];
    logic        wr_ld[$];

    always #5 clk = ~clk;

    pe_out_row_writer #(
        .DATA_WIDTH(8), .HOUT(14), .Iw(7), .Wh(2), .N(4), .OUT_ROWS(2),
        .ADDR_WIDTH(16), .RELU_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .pe2row_data_valid(valid),
        .fifo_array1_dataout(fifo_dout), .fifo_array1_rden(rden),
        .pe2row_ready(ready), .out_wr_en(wr_en), .out_wr_ready(out_wr_ready),
        .out_addr(addr), .out_data(data), .layer_done(ld)
    );

    pe_out_row_writer #(
        .DATA_WIDTH(8), .HOUT(14), .Iw(7), .Wh(2), .N(4), .OUT_ROWS(2),
        .ADDR_WIDTH(16), .RELU_EN(1'b0)
    ) dut_nr (
        .clk(clk), .rst(rst), .pe2row_data_valid(valid),
        .fifo_array1_dataout(fifo_dout), .fifo_array1_rden(nr_rden),
        .pe2row_ready(nr_ready), .out_wr_en(nr_wr_en), .out_wr_ready(out_wr_ready),
        .out_addr(nr_addr), .out_data(nr_data), .layer_done(nr_ld)
    );

    // Upstream FIFO model: data appears the cycle after a read strobe.
    always @(posedge clk) begin
        if (rden[0] && q.size() > 0) fifo_dout <= q.pop_front();
        valid <= (q.size() > 0) && (!gaps || ($urandom_range(0, 2) != 0));
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rden[0]) begin
                rden_cnt++;
                if (!valid) viol++;
            end
            if (ld) ld_cnt++;
            if (wr_en && out_wr_ready) begin
                wr_addr.push_back(addr);
                wr_data.push_back(data);
                wr_nr_data.push_back(nr_data);
                wr_ld.push_back(ld);
            end
        end
    end

    task automatic clear_log();
        rden_cnt = 0; viol = 0; ld_cnt = 0;
        wr_addr.delete(); wr_data.delete(); wr_nr_data.delete(); wr_ld.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; gaps = 1'b0; out_wr_ready = 1'b1; q.delete();
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        clear_log();
    endtask

    task automatic push_group(input logic [7:0] b0, input logic [7:0] b1);
        beat_t bt;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 7; i++) begin
                bt[0][i] = b0 + 8'(s * 7 + i);
                bt[1][i] = b1 + 8'(s * 7 + i);
            end
            q.push_back(bt);
        end
    endtask

    function automatic row_t exp_row(input logic [7:0] b);
        row_t r;
        for (int e = 0; e < 14; e++) r[e] = b + 8'(e);
        return r;
    endfunction

    task automatic wait_writes(input int n);
        int cyc = 0;
        while (wr_addr.size() < n && cyc < 400) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (wr_addr.size() < n) begin
            errors++;
            $display("FAIL wait_writes: got %0d writes, expected %0d", wr_addr.size(), n);
        end
    endtask

    task automatic check_write(input string name, input int k, input logic [15:0] ea, input row_t ed);
        logic [15:0] a;
        row_t d;
        a = (k < wr_addr.size()) ? wr_addr[k] : 16'hFFFF;
        d = (k < wr_data.size()) ? wr_data[k] : '0;
        checks++;
        if (a !== ea) begin
            errors++;
            $display("FAIL %s addr[%0d]: got %0d expected %0d", name, k, a, ea);
        end
        checks++;
        if (d !== ed) begin
            errors++;
            $display("FAIL %s data[%0d]: got %h expected %h", name, k, d, ed);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready, rden, wr_en, ld} !== 5'b0 || addr !== 16'd0 || data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rden=%b wr_en=%b ld=%b addr=%0d data=%h expected all 0",
                     ready, rden, wr_en, ld, addr, data);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || rden !== 2'b00) begin
            errors++;
            $display("FAIL reset_accept: ready=%b rden=%b expected ready=1 rden=00", ready, rden);
        end
    endtask

    task automatic test_basic_row();
        do_reset();
        push_group(8'd0, 8'd100);
        wait_writes(2);
        repeat (10) @(negedge clk);
        check_write("basic", 0, 16'd0, exp_row(8'd0));
        check_write("basic", 1, 16'd1, exp_row(8'd100));
        checks++;
        if (wr_addr.size() != 2 || rden_cnt != 2) begin
            errors++;
            $display("FAIL basic_counts: writes=%0d rden=%0d expected 2 and 2", wr_addr.size(), rden_cnt);
        end
    endtask

    task automatic test_relu();
        beat_t bt;
        row_t  er, en;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 7; i++) begin
                bt[0][i] = (((s * 7 + i) % 2) == 0) ? 8'h85 : 8'h05;
                bt[1][i] = bt[0][i];
            end
            q.push_back(bt);
        end
        for (int e = 0; e < 14; e++) begin
            er[e] = ((e % 2) == 0) ? 8'h00 : 8'h05;
            en[e] = ((e % 2) == 0) ? 8'h85 : 8'h05;
        end
        wait_writes(2);
        check_write("relu_on", 0, 16'd0, er);
        check_write("relu_on", 1, 16'd1, er);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (k >= wr_nr_data.size() || wr_nr_data[k] !== en) begin
                errors++;
                $display("FAIL relu_off data[%0d]: got %h expected %h", k,
                         (k < wr_nr_data.size()) ? wr_nr_data[k] : '0, en);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a0;
        row_t d0;
        int cyc = 0;
        do_reset();
        out_wr_ready = 1'b0;
        push_group(8'd20, 8'd40);
        while (!wr_en && cyc < 100) begin @(negedge clk); cyc++; end
        a0 = addr; d0 = data;
        checks++;
        if (!wr_en || a0 !== 16'd0 || d0 !== exp_row(8'd20)) begin
            errors++;
            $display("FAIL bp_first: wr_en=%b addr=%0d data=%h expected 1, 0, %h", wr_en, a0, d0, exp_row(8'd20));
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (!wr_en || addr !== a0 || data !== d0 || rden !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: wr_en=%b addr=%0d rden=%b expected 1, %0d, 00",
                         c, wr_en, addr, rden, a0);
            end
        end
        @(posedge clk); #1;
        out_wr_ready = 1'b1;
        wait_writes(2);
        repeat (8) @(negedge clk);
        check_write("bp", 0, 16'd0, exp_row(8'd20));
        check_write("bp", 1, 16'd1, exp_row(8'd40));
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL bp_count: writes=%0d expected 2", wr_addr.size());
        end
    endtask

    task automatic test_full_layer();
        do_reset();
        for (int g = 0; g < 4; g++) push_group(8'(g * 10), 8'(g * 10 + 50));
        wait_writes(8);
        for (int k = 0; k < 8; k++) begin
            check_write("layer", k, 16'(k), exp_row(8'((k / 2) * 10 + (k % 2) * 50)));
            checks++;
            if (k >= wr_ld.size() || wr_ld[k] !== (k == 7)) begin
                errors++;
                $display("FAIL layer_done_at[%0d]: got %b expected %b", k,
                         (k < wr_ld.size()) ? wr_ld[k] : 1'bx, (k == 7));
            end
        end
        push_group(8'd5, 8'd60);
        wait_writes(9);
        check_write("layer_wrap", 8, 16'd0, exp_row(8'd5));
        checks++;
        if (ld_cnt != 1) begin
            errors++;
            $display("FAIL layer_done_count: got %0d expected 1", ld_cnt);
        end
    endtask

    task automatic test_valid_gaps();
        do_reset();
        gaps = 1'b1;
        push_group(8'd0, 8'd100);
        push_group(8'd20, 8'd70);
        wait_writes(4);
        repeat (6) @(negedge clk);
        check_write("gaps", 0, 16'd0, exp_row(8'd0));
        check_write("gaps", 1, 16'd1, exp_row(8'd100));
        check_write("gaps", 2, 16'd2, exp_row(8'd20));
        check_write("gaps", 3, 16'd3, exp_row(8'd70));
        checks++;
        if (rden_cnt != 4 || viol != 0) begin
            errors++;
            $display("FAIL gaps_rden: pulses=%0d while_invalid=%0d expected 4 and 0", rden_cnt, viol);
        end
        gaps = 1'b0;
    endtask

    task automatic test_reset_mid_row();
        beat_t bt;
        int cyc = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bt[0][i] = 8'h7F;
            bt[1][i] = 8'h7E;
        end
        q.push_back(bt);
        while (rden_cnt < 1 && cyc < 100) begin @(negedge clk); cyc++; end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({ready, rden, wr_en, ld} !== 5'b0 || addr !== 16'd0 || data !== '0) begin
                errors++;
                $display("FAIL midrst_outputs cycle %0d: ready=%b rden=%b wr_en=%b ld=%b addr=%0d expected all 0",
                         c, ready, rden, wr_en, ld, addr);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_log();
        push_group(8'd0, 8'd100);
        wait_writes(2);
        check_write("midrst", 0, 16'd0, exp_row(8'd0));
        check_write("midrst", 1, 16'd1, exp_row(8'd100));
    endtask

    initial begin
        test_reset();
        test_basic_row();
        test_relu();
        test_backpressure();
        test_full_layer();
        test_valid_gaps();
        test_reset_mid_row();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
